knn_top_regwrap: RTL and testbench
==================================

# knn_top_regwrap

Streaming k-nearest-neighbour engine with a register-style write/read interface. A reference point, then any number of candidate points, are written one dimension word per cycle. The block computes each candidate's squared Euclidean distance to the reference and keeps a sorted list of the k closest. After `done`, the list is read back nearest-first. It sits behind the bus register wrapper of the KNN accelerator and is the whole datapath.

## Interface
- `dataWidth`, 32: width of data words, names and distances.
- `numberOfDimensions`, 5: words per point.
- `maxK`, 16: depth of the sorted result list.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `wr_en` in 1: input word qualifier in LOAD.
- `rd_en` in 1: pop qualifier in READY.
- `start` in 1: level; a rising edge (sampled) begins a new job.
- `done` in 1: level; ends the input stream.
- `k` in 32: number of neighbours, latched on the start edge.
- `dataValueIn` in dataWidth: signed two's-complement dimension word.
- `dataNameOut` out dataWidth: index of the current result point (1-based).
- `dataValueOut` out dataWidth: distance of the current result point.

## Operation
- States: IDLE, LOAD, DRAIN, READY.
  - Reset enters IDLE.
  - Any state goes to LOAD on a sampled start rising edge (start high now, low last cycle); this clears the list, word counter and point index.
- k latch: `k` is latched on the start edge. k=0 yields no results; k>maxK is clamped to maxK.
- LOAD word capture:
  - Each edge with wr_en=1 captures one `dataValueIn`; wr_en=0 stalls.
  - The first numberOfDimensions words form the reference.
  - Each later group of numberOfDimensions words is one candidate, named 1, 2, 3, … in arrival order. The 32-bit name counter wraps.
- Distance arithmetic:
  - Per-dimension difference computed signed in dataWidth+1 bits, then squared.
  - Squares accumulated in 2*dataWidth+8 bits.
  - Result saturates to 2^dataWidth−1 on overflow.
- Sorted-list insertion:
  - The list is sorted ascending by distance.
  - A candidate is inserted ahead of the first entry with strictly larger distance, so ties keep the earlier name first.
  - Entries beyond the latched k are dropped.
- LOAD exit: done=1 sampled in LOAD moves to DRAIN. A partial candidate (fewer than numberOfDimensions words) is discarded.
- DRAIN completes any pending insertion, then goes to READY.
- READY:
  - A read pointer starts at 0 and the outputs present entry[ptr].
  - Each edge with rd_en=1 and ptr<count increments ptr.
  - When ptr≥count (including count=0), both outputs are 0.
- Ignored inputs: rd_en outside READY, and wr_en outside LOAD.
- Reset values: all outputs 0 and the list empty.
- Reset mid-operation aborts the job immediately.

## Timing
- Words are sampled on the rising edge. The first word may be sampled on the edge after the start edge.
- Insertion latency is at most 2 cycles after a candidate's last word. DRAIN lasts ≤2 cycles.
- Outputs are registered:
  - Entry 0 appears on the cycle after entering READY.
  - After a pop edge, the next entry appears one cycle later.
- wr_en and done high on the same edge in LOAD: the word is taken first, then done applies.
- start edge in READY restarts the job and discards the results.

## Test plan
- Reference (1,−2,2,−2,3), k=3, then candidates (5,10,7,9,6), (1×5), (2×5), (2×5), (5×5), then done, then rd_en. Required reads, in order:
  - (name 2, distance 23)
  - (3, 34)
  - (4, 34)
  - then (0, 0).
  - Point 1 (distance 315) and point 5 (distance 127) must be absent.
- Same stream with k=0: first read is (0,0). With k=40 (clamped): all 5 points come out sorted, as 2, 3, 4, 5, 1.
- Stall: toggle wr_en low every other cycle during the first test's stream; results must be identical.
- Partial point: done after 3 words of candidate 6; the result list is unchanged.
- Saturation: reference all 0x7FFFFFFF, candidate all 0x80000000; distance reads 0xFFFFFFFF.
- Reset low mid-LOAD, then a new start and the first test's stream; results match the first test and outputs read 0 during reset.

Source files
------------

// File: rtl/knn_top_regwrap.sv
// knn_top_regwrap: streaming k-nearest-neighbour engine.
// A reference point and then candidate points arrive one dimension word per
// cycle. Each candidate's squared Euclidean distance to the reference is
// computed and inserted into an ascending list that holds at most k entries.
// After done, the list is popped nearest-first through registered outputs.
module knn_top_regwrap #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int maxK               = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 start,
  input  logic                 done,
  input  logic [31:0]          k,
  input  logic [dataWidth-1:0] dataValueIn,
  output logic [dataWidth-1:0] dataNameOut,
  output logic [dataWidth-1:0] dataValueOut
);

  localparam int ACC_W = 2*dataWidth + 8;
  localparam int SQ_W  = 2*(dataWidth + 1);
  localparam int DIM_W = (numberOfDimensions > 1) ? $clog2(numberOfDimensions) : 1;
  localparam int CNT_W = $clog2(maxK + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;

  state_t state, state_nxt;

  logic                        start_q;
  logic                        start_edge;
  logic [CNT_W-1:0]            k_lat;
  logic [DIM_W-1:0]            dim_cnt;
  logic                        have_ref;
  logic [dataWidth-1:0]        name_ctr;

  logic signed [dataWidth-1:0] ref_word [numberOfDimensions];
  logic signed [dataWidth-1:0] ref_sel;
  logic signed [dataWidth:0]   diff;
  logic signed [SQ_W-1:0]      sq;
  logic [ACC_W-1:0]            acc;
  logic [ACC_W-1:0]            acc_sum;
  logic                        capture;
  logic                        last_word;

  logic [dataWidth-1:0]        dist_p0;
  logic [dataWidth-1:0]        name_p0;
  logic                        vld_p0;

  logic [dataWidth-1:0]        list_dist [maxK];
  logic [dataWidth-1:0]        list_name [maxK];
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            ins_pos;
  logic                        do_insert;

  logic [CNT_W-1:0]            rd_ptr;
  logic [dataWidth-1:0]        sel_dist;
  logic [dataWidth-1:0]        sel_name;

  // Clamp an accumulated sum of squares to the output distance width.
  function automatic logic [dataWidth-1:0] sat_dist(input logic [ACC_W-1:0] a);
    if (|a[ACC_W-1:dataWidth]) return '1;
    return a[dataWidth-1:0];
  endfunction

  // Clamp the requested neighbour count to the list depth.
  function automatic logic [CNT_W-1:0] clamp_k(input logic [31:0] kv);
    if (kv > 32'(maxK)) return CNT_W'(maxK);
    return kv[CNT_W-1:0];
  endfunction

  assign start_edge = start && !start_q;
  assign capture    = (state == LOAD) && wr_en && !start_edge;
  assign last_word  = (dim_cnt == DIM_W'(numberOfDimensions - 1));

  // Select the reference word matching the dimension being received.
  always_comb begin
    ref_sel = '0;
    for (int i = 0; i < numberOfDimensions; i++)
      if (DIM_W'(i) == dim_cnt) ref_sel = ref_word[i];
  end

  // Difference is one bit wider than the data so it can never wrap; the
  // square is non-negative so it is zero-extended into the accumulator.
  always_comb begin
    diff    = {dataValueIn[dataWidth-1], dataValueIn} - {ref_sel[dataWidth-1], ref_sel};
    sq      = SQ_W'(diff) * SQ_W'(diff);
    acc_sum = ((dim_cnt == '0) ? '0 : acc) + {{(ACC_W-SQ_W){1'b0}}, sq};
  end

  // Insertion point: first valid entry whose distance is strictly larger.
  always_comb begin
    ins_pos = count;
    for (int i = maxK - 1; i >= 0; i--)
      if ((CNT_W'(i) < count) && (list_dist[i] > dist_p0)) ins_pos = CNT_W'(i);
  end

  assign do_insert = vld_p0 && !start_edge && (ins_pos < k_lat);

  // Read-side mux for the entry currently addressed by the pop pointer.
  always_comb begin
    sel_dist = '0;
    sel_name = '0;
    for (int i = 0; i < maxK; i++)
      if (CNT_W'(i) == rd_ptr) begin
        sel_dist = list_dist[i];
        sel_name = list_name[i];
      end
  end

  // Next-state logic; a start edge restarts from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      LOAD:    if (done) state_nxt = DRAIN;
      DRAIN:   state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
    if (start_edge) state_nxt = LOAD;
  end

  // Control state: FSM, counters, valid flags, list occupancy and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      k_lat        <= '0;
      dim_cnt      <= '0;
      have_ref     <= 1'b0;
      name_ctr     <= '0;
      vld_p0       <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      dataNameOut  <= '0;
      dataValueOut <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      vld_p0  <= 1'b0;
      if (start_edge) begin
        k_lat    <= clamp_k(k);
        dim_cnt  <= '0;
        have_ref <= 1'b0;
        name_ctr <= '0;
        count    <= '0;
        rd_ptr   <= '0;
      end else begin
        if (capture) begin
          if (last_word) begin
            dim_cnt  <= '0;
            have_ref <= 1'b1;
            if (have_ref) begin
              vld_p0   <= 1'b1;
              name_ctr <= name_ctr + 1'b1;
            end
          end else begin
            dim_cnt <= dim_cnt + 1'b1;
          end
        end
        if (do_insert && (count < k_lat)) count <= count + 1'b1;
        if (state == DRAIN) rd_ptr <= '0;
        else if ((state == READY) && rd_en && (rd_ptr < count)) rd_ptr <= rd_ptr + 1'b1;
      end
      if ((state == READY) && !start_edge && (rd_ptr < count)) begin
        dataNameOut  <= sel_name;
        dataValueOut <= sel_dist;
      end else begin
        dataNameOut  <= '0;
        dataValueOut <= '0;
      end
    end
  end

  // ---- stage p0: reference capture, accumulation, finished distance ----
  // Datapath registers; validity is carried by have_ref / dim_cnt / vld_p0.
  always_ff @(posedge clk) begin
    if (capture) begin
      acc <= acc_sum;
      if (!have_ref) begin
        for (int i = 0; i < numberOfDimensions; i++)
          if (DIM_W'(i) == dim_cnt) ref_word[i] <= dataValueIn;
      end else if (last_word) begin
        dist_p0 <= sat_dist(acc_sum);
        name_p0 <= name_ctr + 1'b1;
      end
    end
  end

  // ---- stage p1: sorted insertion, shifting larger entries down ----
  // Entries pushed past index k-1 fall outside count and are never read.
  always_ff @(posedge clk) begin
    if (do_insert) begin
      for (int i = 0; i < maxK; i++)
        if (CNT_W'(i) == ins_pos) begin
          list_dist[i] <= dist_p0;
          list_name[i] <= name_p0;
        end
      for (int i = 1; i < maxK; i++)
        if (CNT_W'(i) > ins_pos) begin
          list_dist[i] <= list_dist[i-1];
          list_name[i] <= list_name[i-1];
        end
    end
  end

endmodule

// File: tb/tb_knn_top_regwrap.sv
// Testbench for knn_top_regwrap: directed test-plan jobs plus randomized jobs
// checked against a sort-based reference model.
module tb_knn_top_regwrap;

  localparam int DW = 32;
  localparam int ND = 5;
  localparam int MK = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          start;
  logic          done;
  logic [31:0]   k;
  logic [DW-1:0] dataValueIn;
  logic [DW-1:0] dataNameOut;
  logic [DW-1:0] dataValueOut;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] stream[$];
  logic [31:0] exp_name[$];
  logic [31:0] exp_dist[$];

  knn_top_regwrap #(.dataWidth(DW), .numberOfDimensions(ND), .maxK(MK)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .start        (start),
    .done         (done),
    .k            (k),
    .dataValueIn  (dataValueIn),
    .dataNameOut  (dataNameOut),
    .dataValueOut (dataValueOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic push5(input int a, input int b, input int c, input int d, input int e);
    stream.push_back(32'(a)); stream.push_back(32'(b)); stream.push_back(32'(c));
    stream.push_back(32'(d)); stream.push_back(32'(e));
  endtask

  task automatic build_test1_stream();
    stream.delete();
    push5(1, -2, 2, -2, 3);
    push5(5, 10, 7, 9, 6);
    push5(1, 1, 1, 1, 1);
    push5(2, 2, 2, 2, 2);
    push5(2, 2, 2, 2, 2);
    push5(5, 5, 5, 5, 5);
  endtask

  // Reference model: full squared distance for every complete candidate,
  // stable ascending sort, then keep the first min(k, MK).
  task automatic build_model(input logic [31:0] kk);
    logic [31:0] sd[$];
    logic [31:0] sn[$];
    int nc, keep, idx;
    logic [71:0] s;
    logic signed [32:0] a, r, df;
    logic signed [65:0] sq;
    logic [31:0] dv;
    exp_name.delete();
    exp_dist.delete();
    nc = stream.size() / ND - 1;
    for (int c = 1; c <= nc; c++) begin
      s = '0;
      for (int d = 0; d < ND; d++) begin
        a  = $signed({stream[c*ND+d][31], stream[c*ND+d]});
        r  = $signed({stream[d][31], stream[d]});
        df = a - r;
        sq = 66'(df) * 66'(df);
        s  = s + 72'(sq);
      end
      dv  = (s > 72'h0FFFFFFFF) ? 32'hFFFFFFFF : s[31:0];
      idx = 0;
      while (idx < sd.size() && sd[idx] <= dv) idx++;
      sd.insert(idx, dv);
      sn.insert(idx, 32'(c));
    end
    keep = (kk > 32'(MK)) ? MK : int'(kk);
    for (int i = 0; i < keep && i < sd.size(); i++) begin
      exp_name.push_back(sn[i]);
      exp_dist.push_back(sd[i]);
    end
  endtask

  task automatic run_job(input logic [31:0] kk, input bit stall, input bit same_edge);
    k = kk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      if (stall && (i % 2 == 1)) begin
        wr_en = 1'b0;
        dataValueIn = $urandom;
        @(negedge clk);
      end
      wr_en = 1'b1;
      dataValueIn = stream[i];
      if (same_edge && i == stream.size() - 1) done = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      done  = 1'b0;
    end
    if (!same_edge) begin
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic read_check(input string tag);
    int n;
    n = exp_name.size();
    for (int i = 0; i < n + 2; i++) begin
      check($sformatf("%s_name%0d", tag, i), dataNameOut,  (i < n) ? exp_name[i] : 32'd0);
      check($sformatf("%s_dist%0d", tag, i), dataValueOut, (i < n) ? exp_dist[i] : 32'd0);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic set_exp_test1();
    exp_name = '{32'd2, 32'd3, 32'd4};
    exp_dist = '{32'd23, 32'd34, 32'd34};
  endtask

  initial begin
    int nc, partial, mode;
    logic [31:0] kk;
    bit stall, same_edge;

    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; start = 1'b0; done = 1'b0;
    k = '0; dataValueIn = '0;
    repeat (3) @(negedge clk);
    check("reset_name", dataNameOut, 32'd0);
    check("reset_dist", dataValueOut, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic k=3 job
    build_test1_stream();
    set_exp_test1();
    run_job(32'd3, 1'b0, 1'b0);
    read_check("t1");

    // k=0 yields nothing
    exp_name.delete(); exp_dist.delete();
    run_job(32'd0, 1'b0, 1'b0);
    read_check("k0");

    // k=40 clamps to the list depth: all five come out
    exp_name = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd1};
    exp_dist = '{32'd23, 32'd34, 32'd34, 32'd127, 32'd315};
    run_job(32'd40, 1'b0, 1'b0);
    read_check("k40");

    // Stalled stream, done on the same edge as the final word
    set_exp_test1();
    run_job(32'd3, 1'b1, 1'b1);
    read_check("stall");

    // Partial sixth candidate is discarded
    stream.push_back(32'd0); stream.push_back(32'd0); stream.push_back(32'd0);
    set_exp_test1();
    run_job(32'd3, 1'b0, 1'b0);
    read_check("partial");

    // Saturating distance
    stream.delete();
    for (int i = 0; i < ND; i++) stream.push_back(32'h7FFFFFFF);
    for (int i = 0; i < ND; i++) stream.push_back(32'h80000000);
    exp_name = '{32'd1};
    exp_dist = '{32'hFFFFFFFF};
    run_job(32'd3, 1'b0, 1'b0);
    read_check("sat");

    // Reset while results are presented, then reset mid-LOAD
    build_test1_stream();
    set_exp_test1();
    run_job(32'd3, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_ready_name", dataNameOut, 32'd0);
    check("rst_ready_dist", dataValueOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    k = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      dataValueIn = stream[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_load_name", dataNameOut, 32'd0);
    check("rst_load_dist", dataValueOut, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_job(32'd3, 1'b0, 1'b0);
    read_check("after_rst");

    // Randomized jobs against the reference model
    for (int t = 0; t < 8; t++) begin
      stream.delete();
      nc      = $urandom_range(1, 20);
      partial = $urandom_range(0, ND - 1);
      mode    = $urandom_range(0, 2);
      for (int i = 0; i < (nc + 1) * ND + partial; i++) begin
        if (mode == 0)      stream.push_back(32'($urandom_range(0, 8)) - 32'd4);
        else if (mode == 1) stream.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
        else                stream.push_back($urandom);
      end
      kk        = 32'($urandom_range(0, 20));
      stall     = 1'($urandom_range(0, 1));
      same_edge = 1'($urandom_range(0, 1));
      build_model(kk);
      run_job(kk, stall, same_edge);
      read_check($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
